// File: rtl/q_policy_reader.sv
// q_policy_reader: sweeps all grid states, reads the action Q values of each state from the
// Q table read port, picks the greedy (argmax) action and streams one {state, action, qmax}
// record per state over a valid/ready interface.
//
// Ports:
//   clk        clock
//   rst        asynchronous active-low reset
//   start      one-cycle sweep request, honoured only when idle
//   busy       high from the cycle after start is accepted until the done cycle
//   done       one-cycle pulse after the last record is accepted
//   q_rd_en    Q table read enable
//   q_rd_addr  Q table read address {state, action}
//   q_rd_data  Q table read data, valid one cycle after q_rd_en
//   pol_valid  policy record valid
//   pol_ready  downstream accepts the record
//   pol_state  record state index
//   pol_action record greedy action (ties keep the lowest action index)
//   pol_qmax   Q value of the greedy action
module q_policy_reader #(
  parameter int unsigned STATE_BITS  = 6,
  parameter int unsigned ACTION_BITS = 2,
  parameter int unsigned DATA_WIDTH  = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  output logic                              q_rd_en,
  output logic [STATE_BITS+ACTION_BITS-1:0] q_rd_addr,
  input  logic [DATA_WIDTH-1:0]             q_rd_data,
  output logic                              pol_valid,
  input  logic                              pol_ready,
  output logic [STATE_BITS-1:0]             pol_state,
  output logic [ACTION_BITS-1:0]            pol_action,
  output logic [DATA_WIDTH-1:0]             pol_qmax
);

  localparam logic [STATE_BITS-1:0]  LastState = '1;
  localparam logic [ACTION_BITS-1:0] LastAct   = '1;

  typedef enum logic [2:0] {StIdle, StRead, StDrain, StOut, StFin} st_e;

  st_e                    st_q, st_d;
  logic [STATE_BITS-1:0]  state_cnt_q, state_cnt_d;
  logic [ACTION_BITS-1:0] act_cnt_q, act_cnt_d;
  logic                   rd_pending_q, rd_pending_d;
  logic [ACTION_BITS-1:0] tag_q, tag_d;
  logic [DATA_WIDTH-1:0]  best_q, best_d;
  logic [ACTION_BITS-1:0] best_a_q, best_a_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   q_rd_en_q, q_rd_en_d;
  logic                   pol_valid_q, pol_valid_d;
  logic [STATE_BITS-1:0]  pol_state_q, pol_state_d;
  logic [ACTION_BITS-1:0] pol_action_q, pol_action_d;
  logic [DATA_WIDTH-1:0]  pol_qmax_q, pol_qmax_d;

  // Compare stage: the pending flag and action tag trail each read by one cycle so they line up
  // with the returned data.
  always_comb begin
    rd_pending_d = q_rd_en_q;
    tag_d        = act_cnt_q;
    best_d       = best_q;
    best_a_d     = best_a_q;
    if (rd_pending_q) begin
      if (tag_q == '0) begin
        best_d   = q_rd_data;
        best_a_d = '0;
      end else if (q_rd_data > best_q) begin
        // Strict compare: a tie keeps the earlier (lower) action.
        best_d   = q_rd_data;
        best_a_d = tag_q;
      end
    end
  end

  // Sweep control and registered outputs.
  always_comb begin
    st_d         = st_q;
    state_cnt_d  = state_cnt_q;
    act_cnt_d    = act_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    q_rd_en_d    = q_rd_en_q;
    pol_valid_d  = pol_valid_q;
    pol_state_d  = pol_state_q;
    pol_action_d = pol_action_q;
    pol_qmax_d   = pol_qmax_q;
    unique case (st_q)
      StIdle: begin
        if (start) begin
          st_d        = StRead;
          state_cnt_d = '0;
          act_cnt_d   = '0;
          q_rd_en_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      StRead: begin
        if (act_cnt_q == LastAct) begin
          st_d      = StDrain;
          q_rd_en_d = 1'b0;
        end else begin
          act_cnt_d = act_cnt_q + 1'b1;
        end
      end
      StDrain: begin
        // The last action's compare resolves on this edge, so capture the next-state values.
        st_d         = StOut;
        pol_valid_d  = 1'b1;
        pol_state_d  = state_cnt_q;
        pol_action_d = best_a_d;
        pol_qmax_d   = best_d;
      end
      StOut: begin
        if (pol_ready) begin
          pol_valid_d = 1'b0;
          if (state_cnt_q == LastState) begin
            st_d   = StFin;
            done_d = 1'b1;
          end else begin
            st_d        = StRead;
            state_cnt_d = state_cnt_q + 1'b1;
            act_cnt_d   = '0;
            q_rd_en_d   = 1'b1;
          end
        end
      end
      StFin: begin
        st_d        = StIdle;
        busy_d      = 1'b0;
        state_cnt_d = '0;
        act_cnt_d   = '0;
      end
      default: begin
        st_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q         <= StIdle;
      state_cnt_q  <= '0;
      act_cnt_q    <= '0;
      rd_pending_q <= 1'b0;
      tag_q        <= '0;
      best_q       <= '0;
      best_a_q     <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      q_rd_en_q    <= 1'b0;
      pol_valid_q  <= 1'b0;
      pol_state_q  <= '0;
      pol_action_q <= '0;
      pol_qmax_q   <= '0;
    end else begin
      st_q         <= st_d;
      state_cnt_q  <= state_cnt_d;
      act_cnt_q    <= act_cnt_d;
      rd_pending_q <= rd_pending_d;
      tag_q        <= tag_d;
      best_q       <= best_d;
      best_a_q     <= best_a_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      q_rd_en_q    <= q_rd_en_d;
      pol_valid_q  <= pol_valid_d;
      pol_state_q  <= pol_state_d;
      pol_action_q <= pol_action_d;
      pol_qmax_q   <= pol_qmax_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign q_rd_en    = q_rd_en_q;
  assign q_rd_addr  = {state_cnt_q, act_cnt_q};
  assign pol_valid  = pol_valid_q;
  assign pol_state  = pol_state_q;
  assign pol_action = pol_action_q;
  assign pol_qmax   = pol_qmax_q;

endmodule

// File: tb/tb_q_policy_reader.sv
// Bench for q_policy_reader: a Q table memory model answers reads one cycle later, expected
// records are queued when each sweep is launched and popped on every handshake.
module tb_q_policy_reader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy;
  logic       done;
  logic       q_rd_en;
  logic [7:0] q_rd_addr;
  logic [7:0] q_rd_data;
  logic       pol_valid;
  logic       pol_ready;
  logic [5:0] pol_state;
  logic [1:0] pol_action;
  logic [7:0] pol_qmax;

  logic [7:0]  mem [256];
  logic [15:0] exp_q [$];
  int errors;
  int checks;
  int done_cnt;
  int rec_cnt;
  bit stall_prev;
  logic [15:0] snap;

  q_policy_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .q_rd_en    (q_rd_en),
    .q_rd_addr  (q_rd_addr),
    .q_rd_data  (q_rd_data),
    .pol_valid  (pol_valid),
    .pol_ready  (pol_ready),
    .pol_state  (pol_state),
    .pol_action (pol_action),
    .pol_qmax   (pol_qmax)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Q table read port model: one-cycle read latency.
  always @(posedge clk) begin
    if (q_rd_en) q_rd_data <= mem[q_rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Greedy reference: first maximum wins.
  task automatic push_expected();
    logic [7:0] b;
    logic [1:0] a;
    logic [5:0] s6;
    for (int s = 0; s < 64; s++) begin
      b = mem[s*4];
      a = 2'd0;
      for (int i = 1; i < 4; i++) begin
        if (mem[s*4+i] > b) begin
          b = mem[s*4+i];
          a = 2'(i);
        end
      end
      s6 = 6'(s);
      exp_q.push_back({s6, a, b});
    end
  endtask

  // Record monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(pol_valid), 32'd1);
        check("stall_hold", 32'({pol_state, pol_action, pol_qmax}), 32'(snap));
        check("stall_no_rd", 32'(q_rd_en), 32'd0);
      end
      if (done) done_cnt++;
      if (pol_valid && pol_ready) begin
        if (exp_q.size() == 0) begin
          check("rec_unexpected", 32'(pol_valid), 32'd0);
        end else begin
          logic [15:0] rec;
          rec = exp_q.pop_front();
          check("rec_state", 32'(pol_state), 32'(rec[15:10]));
          check("rec_action", 32'(pol_action), 32'(rec[9:8]));
          check("rec_qmax", 32'(pol_qmax), 32'(rec[7:0]));
          rec_cnt++;
        end
      end
      stall_prev = pol_valid && !pol_ready;
      snap = {pol_state, pol_action, pol_qmax};
    end
  end

  // Launches a sweep and tracks it to done; cycle n is the n-th cycle after start is sampled.
  task automatic run_sweep(input int stall_state, input int restart_state,
                           output int t_rd, output int t_val, output int t_done);
    int n;
    int stall_left;
    bit restarted;
    push_expected();
    done_cnt   = 0;
    rec_cnt    = 0;
    t_rd       = -1;
    t_val      = -1;
    t_done     = -1;
    stall_left = 10;
    restarted  = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    pol_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 2000) begin
      if (q_rd_en && t_rd < 0) t_rd = n;
      if (pol_valid && t_val < 0) t_val = n;
      if (stall_state >= 0 && pol_valid && int'(pol_state) == stall_state && stall_left > 0) begin
        pol_ready = 1'b0;
        stall_left--;
      end else begin
        pol_ready = 1'b1;
      end
      if (!restarted && restart_state >= 0 && q_rd_en && int'(q_rd_addr[7:2]) == restart_state)
      begin
        start     = 1'b1;
        restarted = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        t_done = n;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    start     = 1'b0;
    pol_ready = 1'b1;
    check("sweep_finished", 32'(t_done >= 0), 32'd1);
  endtask

  task automatic check_after(input string tag, input int t_rd, input int t_val, input int t_done,
                             input int exp_done);
    check({tag, "_first_rd"}, 32'(t_rd), 32'd1);
    check({tag, "_first_valid"}, 32'(t_val), 32'd6);
    check({tag, "_done_cycle"}, 32'(t_done), 32'(exp_done));
    @(posedge clk); #1;
    check({tag, "_busy_low"}, 32'(busy), 32'd0);
    check({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    check({tag, "_records"}, 32'(rec_cnt), 32'd64);
    check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_rd_en"}, 32'(q_rd_en), 32'd0);
    check({tag, "_rd_addr"}, 32'(q_rd_addr), 32'd0);
    check({tag, "_valid"}, 32'(pol_valid), 32'd0);
    check({tag, "_state"}, 32'(pol_state), 32'd0);
    check({tag, "_action"}, 32'(pol_action), 32'd0);
    check({tag, "_qmax"}, 32'(pol_qmax), 32'd0);
  endtask

  initial begin
    int t_rd, t_val, t_done, n;
    errors     = 0;
    checks     = 0;
    done_cnt   = 0;
    rec_cnt    = 0;
    stall_prev = 1'b0;
    snap       = '0;
    rst        = 1'b0;
    start      = 1'b0;
    pol_ready  = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // All-zero table.
    run_sweep(-1, -1, t_rd, t_val, t_done);
    check_after("zero", t_rd, t_val, t_done, 385);

    // Tie in state 5, max unsigned value in the final state.
    mem[5*4+0] = 8'h10;
    mem[5*4+1] = 8'h30;
    mem[5*4+2] = 8'h20;
    mem[5*4+3] = 8'h30;
    mem[63*4+3] = 8'hFF;
    run_sweep(-1, -1, t_rd, t_val, t_done);
    check_after("tie_max", t_rd, t_val, t_done, 385);

    // Varied table for the remaining sweeps.
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
    mem[7*4+0] = 8'h44;
    mem[7*4+1] = 8'h44;
    mem[7*4+2] = 8'h44;
    mem[7*4+3] = 8'h44;

    // Backpressure on the state 2 record.
    run_sweep(2, -1, t_rd, t_val, t_done);
    check_after("stall", t_rd, t_val, t_done, 395);

    // Start while busy is ignored.
    run_sweep(-1, 10, t_rd, t_val, t_done);
    check_after("restart", t_rd, t_val, t_done, 385);

    // Reset in the middle of reading state 20.
    push_expected();
    done_cnt = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (!(q_rd_en && q_rd_addr[7:2] == 6'd20) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_state20", 32'(q_rd_en && q_rd_addr[7:2] == 6'd20), 32'd1);
    rst = 1'b0;
    #1;
    check_reset_outputs("midreset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    check("midreset_no_done", 32'(done_cnt), 32'd0);
    check("midreset_busy", 32'(busy), 32'd0);
    rst = 1'b1;
    run_sweep(-1, -1, t_rd, t_val, t_done);
    check_after("post_reset", t_rd, t_val, t_done, 385);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
